div_pipeline: RTL
=================

Name: div_pipeline

Overview:
- Pipelined unsigned restoring divider; the inverse-operation companion to the team's pipelined multiplier. It uses the same operand widths and the same data_rdy/res_rdy streaming handshake.
- Accepts one dividend/divisor pair per cycle.
- Produces quotient and remainder after a fixed latency of N cycles.
- One restoring-division step per pipeline stage.
- No backpressure. Downstream consumes every result on the cycle res_rdy is high.

Parameters:
- N, 8, dividend and quotient width in bits; also the number of pipeline stages.
- M, 4, divisor and remainder width in bits. Requires M <= N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- data_rdy  input  1  operands valid this cycle.
- dividend  input  N  unsigned dividend.
- divisor  input  M  unsigned divisor.
- res_rdy  output  1  quotient/remainder/div_zero valid this cycle.
- quotient  output  N  unsigned quotient.
- remainder  output  M  unsigned remainder.
- div_zero  output  1  result came from divisor==0.

Behaviour:
- Reset:
  - rst high at a rising edge clears every stage valid bit and all stage datapath registers.
  - res_rdy, quotient, remainder and div_zero are 0 from the following cycle.
  - In-flight operations are discarded, never emitted.
  - With rst held, inputs are ignored.
- Pipeline:
  - N register stages, S0..S(N-1). Each holds:
    - valid
    - partial remainder (M+1 bits)
    - quotient bits so far (N)
    - unconsumed dividend bits (N)
    - divisor (M)
    - zero flag
  - Stage k resolves quotient bit N-1-k:
    - t = {partial_rem[M-1:0], next dividend MSB}
    - if t >= divisor: rem = t - divisor, qbit = 1
    - else: rem = t, qbit = 0
  - S0 operates directly on input ports, with partial remainder 0.
  - Compare/subtract width is M+1 bits, so there is no overflow. Final remainder always < divisor and fits M bits.
- Latency and throughput:
  - Operands sampled at edge e (data_rdy=1) produce results from just after edge e+N-1 until edge e+N.
  - Latency is exactly N cycles, independent of operand values.
  - Throughput: one result per cycle. Back-to-back data_rdy gives back-to-back res_rdy.
  - data_rdy=0 inserts a bubble that propagates; res_rdy=0 exactly N cycles later.
  - Results leave in input order.
- Output gating: when res_rdy=0, quotient, remainder and div_zero are driven 0. They are registered outputs; no combinational input-to-output path.
- Divide by zero (divisor==0):
  - quotient = all ones (2^N-1)
  - remainder = 0
  - div_zero = 1
  - Same latency; flag travels with the operation.
- Normal results:
  - quotient = floor(dividend/divisor)
  - remainder = dividend mod divisor
  - div_zero = 0
- Identity check: quotient*divisor + remainder == dividend whenever div_zero=0. The bench checks this against a delay-line reference of depth N.
- Reset mid-stream: rst asserted for 1 cycle while the pipe is full.
  - No res_rdy for any operand sampled at or before the reset edge.
  - The first res_rdy appears N cycles after the first post-reset data_rdy.
- Simultaneous rst and data_rdy: rst wins; the operand is dropped.

Test Plan:
- Reset then data_rdy with pairs (25,5),(200,7),(255,15),(3,11) on consecutive cycles -> res_rdy on 4 consecutive cycles starting exactly 8 cycles after the first sample. Results (q,r): (5,0),(28,4),(17,0),(0,3).
- (10,0) between (100,9) and (9,1) -> (11,1,div_zero=0), (255,0,div_zero=1), (9,0,div_zero=0). Flag is high only on the middle result.
- Bubbles: data_rdy pattern 1,0,0,1 with (16,10),(x),(x),(15,7) -> res_rdy pattern 1,0,0,1. Results (1,6),(2,1); quotient/remainder 0 during the bubbles.
- Sweep: divisor in {7,1,15,3,11,4,9}, dividend incrementing 15..46 every cycle for each divisor -> every cycle, res_rdy=1 and q*d+r==dividend from the N-deep reference; error flag never set.
- Reset mid-stream: 5 operands issued, rst high one cycle at the 5th sample edge -> zero res_rdy pulses for those 5. The next issued (255,1) returns (255,0) exactly 8 cycles later.
- Hold rst high for 3 cycles with data_rdy=1 -> res_rdy stays 0 through reset and for 8 cycles after release when data_rdy is resumed at release.

Source files
------------

// File: rtl/div_if.sv
// Streaming handshake bundle for the pipelined divider.
//   master : operand source (drives data_rdy/dividend/divisor, receives results)
//   slave  : divider (receives operands, drives res_rdy/quotient/remainder/div_zero)
// Signals:
//   data_rdy  operands valid this cycle
//   dividend  N-bit unsigned dividend
//   divisor   M-bit unsigned divisor
//   res_rdy   result valid this cycle
//   quotient  N-bit unsigned quotient
//   remainder M-bit unsigned remainder
//   div_zero  result came from a zero divisor
interface div_if #(
  parameter int N = 8,
  parameter int M = 4
) ();
  logic         data_rdy;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         res_rdy;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_zero;

  modport master (
    output data_rdy, dividend, divisor,
    input  res_rdy, quotient, remainder, div_zero
  );

  modport slave (
    input  data_rdy, dividend, divisor,
    output res_rdy, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_pipeline.sv
// Pipelined unsigned restoring divider, one quotient bit resolved per stage.
// Accepts one operand pair per cycle; the result appears exactly N cycles
// after the operands are sampled, in issue order, with no backpressure.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; flushes every stage
//   io_bus div_if slave: data_rdy/dividend/divisor in,
//          res_rdy/quotient/remainder/div_zero out (all registered;
//          result fields are 0 whenever res_rdy is 0)
module div_pipeline #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  io_bus
);

  typedef struct packed {
    logic         vld;
    logic [M:0]   rem;   // partial remainder, one spare bit for the compare
    logic [N-1:0] quo;   // quotient bits resolved so far, MSB first
    logic [N-1:0] dvd;   // dividend bits not yet consumed, left-justified
    logic [M-1:0] dsr;
    logic         zero;
  } stage_t;

  stage_t r_stg [N];
  stage_t w_in  [N];
  stage_t w_nxt [N];

  // One restoring step: shift in the next dividend bit and try to subtract.
  // Bubbles produce an all-zero stage so result fields read 0 when invalid.
  function automatic stage_t div_step(input stage_t s);
    stage_t     nx;
    logic [M:0] t;
    logic       qbit;
    nx = '0;
    if (s.vld) begin
      t = {s.rem[M-1:0], s.dvd[N-1]};
      if (t >= {1'b0, s.dsr}) begin
        nx.rem = t - {1'b0, s.dsr};
        qbit   = 1'b1;
      end else begin
        nx.rem = t;
        qbit   = 1'b0;
      end
      nx.vld  = 1'b1;
      nx.quo  = {s.quo[N-2:0], qbit};
      nx.dvd  = {s.dvd[N-2:0], 1'b0};
      nx.dsr  = s.dsr;
      nx.zero = s.zero;
    end
    return nx;
  endfunction

  // A zero divisor naturally yields an all-ones quotient, but the partial
  // remainder ends up holding the dividend's low bits; force it to 0.
  function automatic stage_t finalize(input stage_t s);
    stage_t nx;
    nx = s;
    if (s.zero) nx.rem = '0;
    return nx;
  endfunction

  always_comb begin
    w_in[0]      = '0;
    w_in[0].vld  = io_bus.data_rdy;
    w_in[0].dvd  = io_bus.dividend;
    w_in[0].dsr  = io_bus.divisor;
    w_in[0].zero = (io_bus.divisor == '0);
    for (int k = 1; k < N; k++) begin
      w_in[k] = r_stg[k-1];
    end
    for (int k = 0; k < N; k++) begin
      w_nxt[k] = div_step(w_in[k]);
    end
    w_nxt[N-1] = finalize(w_nxt[N-1]);
  end

  // Stage registers S0..S(N-1); reset flushes valid and data alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r_stg[k] <= w_nxt[k];
      end
    end
  end

  assign io_bus.res_rdy   = r_stg[N-1].vld;
  assign io_bus.quotient  = r_stg[N-1].quo;
  assign io_bus.remainder = r_stg[N-1].rem[M-1:0];
  assign io_bus.div_zero  = r_stg[N-1].zero;

endmodule
